// File: rtl/bng_pkg.sv
// Shared types and constants for the binary number game round controller.
package bng_pkg;

    localparam int TIME_W  = 5;
    localparam int LIVES_W = 2;

    // Feedback taps at bits 7, 5, 4 and 3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        CHECK,
        SHOW,
        OVER
    } state_t;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bng_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; a non-zero seed keeps it off the all-zero lock-up state.
module bng_lfsr8
    import bng_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] value_o
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the binary number game: target pick, timer arming, guess scoring.
// Build option BNG_TIME_BONUS_EN adds the seconds left at submit time to the score on a hit.
//
// state | meaning
// IDLE  | waiting for the first start
// LOAD  | strobe round time into the timer, latch a new target
// PLAY  | round running, waiting for submit or timer expiry
// CHECK | compare latched guess against target
// SHOW  | hold the round result for RESULT_CYCLES cycles
// OVER  | no lives left, waiting for start
module game_round_ctrl
    import bng_pkg::*;
#(
    parameter int         TARGET_W      = 8,
    parameter int         START_TIME    = 20,
    parameter int         MIN_TIME      = 5,
    parameter int         TIME_STEP     = 1,
    parameter int         LIVES         = 3,
    parameter int         RESULT_CYCLES = 50000000,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                submit,
    input  logic [TARGET_W-1:0] guess,
    input  logic                tmr_end,
    input  logic [TIME_W-1:0]   tmr_left,
    output logic                tmr_load,
    output logic [TIME_W-1:0]   tmr_value,
    output logic [TARGET_W-1:0] target,
    output logic [TARGET_W-1:0] score,
    output logic [LIVES_W-1:0]  lives,
    output logic [3:0]          level,
    output logic                hit,
    output logic                playing,
    output logic                game_over
);

    localparam int                 CNT_W      = $clog2(RESULT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(RESULT_CYCLES - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam int                 SUM_W      = TARGET_W + TIME_W + 1;

    state_t              state_q, state_d;
    logic [TARGET_W-1:0] target_q, target_d;
    logic [TARGET_W-1:0] score_q, score_d;
    logic [TARGET_W-1:0] guess_q, guess_d;
    logic [LIVES_W-1:0]  lives_q, lives_d;
    logic [3:0]          level_q, level_d;
    logic                hit_q, hit_d;
    logic                fresh_q, fresh_d;
    logic [CNT_W-1:0]    hold_q, hold_d;

    logic [7:0]          lfsr;
    logic [TIME_W-1:0]   round_time;
    int                  time_cut;
    logic [TIME_W-1:0]   bonus;
    logic [SUM_W-1:0]    score_sum;
    logic [TARGET_W-1:0] score_hit;
    logic [LIVES_W-1:0]  lives_dec;
    logic [3:0]          level_inc;

    bng_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .value_o (lfsr)
    );

`ifdef BNG_TIME_BONUS_EN
    logic [TIME_W-1:0] bonus_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bonus_q <= '0;
        end else if (state_q == PLAY && submit) begin
            bonus_q <= tmr_left;
        end
    end

    assign bonus = bonus_q;
`else
    logic unused_tmr_left;

    assign unused_tmr_left = ^tmr_left;
    assign bonus           = '0;
`endif

    // Signed arithmetic so a large level simply drops below the floor instead of wrapping.
    always_comb begin
        time_cut = int'(level_q) * TIME_STEP;
        if (START_TIME - time_cut < MIN_TIME) begin
            round_time = TIME_W'(MIN_TIME);
        end else begin
            round_time = TIME_W'(START_TIME - time_cut);
        end
    end

    assign score_sum = SUM_W'(score_q) + SUM_W'(bonus) + SUM_W'(1);
    assign score_hit = (|score_sum[SUM_W-1:TARGET_W]) ? '1 : score_sum[TARGET_W-1:0];
    assign lives_dec = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
    assign level_inc = (level_q == 4'hF) ? level_q : level_q + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            score_q  <= '0;
            guess_q  <= '0;
            lives_q  <= LIVES_INIT;
            level_q  <= '0;
            hit_q    <= 1'b0;
            fresh_q  <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            score_q  <= score_d;
            guess_q  <= guess_d;
            lives_q  <= lives_d;
            level_q  <= level_d;
            hit_q    <= hit_d;
            fresh_q  <= fresh_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        score_d   = score_q;
        guess_d   = guess_q;
        lives_d   = lives_q;
        level_d   = level_q;
        hit_d     = hit_q;
        hold_d    = hold_q;
        fresh_d   = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = '0;

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    score_d = '0;
                    lives_d = LIVES_INIT;
                    level_d = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tmr_load  = 1'b1;
                tmr_value = round_time;
                target_d  = TARGET_W'(lfsr);
                fresh_d   = 1'b1;
                state_d   = PLAY;
            end
            PLAY: begin
                // The timer may still show the previous round's expiry right after a load.
                if (submit) begin
                    guess_d = guess;
                    state_d = CHECK;
                end else if (tmr_end && !fresh_q) begin
                    hit_d   = 1'b0;
                    lives_d = lives_dec;
                    hold_d  = HOLD_LAST;
                    state_d = SHOW;
                end
            end
            CHECK: begin
                if (guess_q == target_q) begin
                    hit_d   = 1'b1;
                    score_d = score_hit;
                    level_d = level_inc;
                end else begin
                    hit_d   = 1'b0;
                    lives_d = lives_dec;
                end
                hold_d  = HOLD_LAST;
                state_d = SHOW;
            end
            SHOW: begin
                if (hold_q == '0) begin
                    state_d = (lives_q == '0) ? OVER : LOAD;
                end else begin
                    hold_d = hold_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign target    = target_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign level     = level_q;
    assign hit       = hit_q;
    assign playing   = (state_q == PLAY);
    assign game_over = (state_q == OVER);

endmodule
